// File: rtl/pixel_stream_sink_if.sv
// Pixel stream (renderer -> sink) and framebuffer write bus (sink -> framebuffer).
// The master modport is the environment side; the slave modport is the sink.
interface pixel_stream_sink_if #(
  parameter int unsigned ADDR_WIDTH = 19
);
  logic                  valid;
  logic                  ready;
  logic [7:0]            r;
  logic [7:0]            g;
  logic [7:0]            b;
  logic                  first;
  logic                  last_x;
  logic                  last_y;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [23:0]           wr_data;

  modport master (
    output valid, r, g, b, first, last_x, last_y, wr_ready,
    input  ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  valid, r, g, b, first, last_x, last_y, wr_ready,
    output ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: checks frame framing, turns accepted pixels into framebuffer writes via a FIFO.
// Optional FRAME_CHECKSUM_EN keeps a per-frame sum of the written pixel data.
module pixel_stream_sink #(
  parameter int unsigned X_RES      = 640,
  parameter int unsigned Y_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_stream_sink_if.slave   bus,
  output logic                 frame_done,
  output logic                 err_pulse,
  output logic [7:0]           err_count,
  output logic [15:0]          frame_count,
  output logic [23:0]          frame_checksum
);

  localparam int unsigned XW = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int unsigned YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;
  localparam int unsigned IW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned EW = ADDR_WIDTH + 24;
  // Flags expected on pixel (0,0); only non-zero for degenerate 1-wide / 1-tall frames.
  localparam logic SOF_LX = (X_RES == 1);
  localparam logic SOF_LY = (X_RES == 1) && (Y_RES == 1);

  typedef enum logic {WAIT_SOF, IN_FRAME} state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]           wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic [23:0]           beat;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  adv;
  logic                  exp_first;
  logic                  exp_lx;
  logic                  exp_ly;
  logic [XW-1:0]         base_x;
  logic [YW-1:0]         base_y;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [PW-1:0]         count_d;

  assign beat      = {bus.b, bus.g, bus.r};
  assign accept    = bus.valid && ready_q;
  assign pop       = wr_en_q && bus.wr_ready;
  assign exp_first = (x_q == '0) && (y_q == '0);
  assign exp_lx    = (x_q == XW'(X_RES - 1));
  assign exp_ly    = exp_lx && (y_q == YW'(Y_RES - 1));

  // Framing FSM and position tracking; base_* is the position the pushed beat occupies.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;
    adv         = 1'b0;
    base_x      = x_q;
    base_y      = y_q;
    base_addr   = addr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      WAIT_SOF: begin
        if (accept && bus.first) begin
          push      = 1'b1;
          adv       = 1'b1;
          base_x    = '0;
          base_y    = '0;
          base_addr = '0;
          state_d   = IN_FRAME;
          if (SOF_LY && bus.last_y && (bus.last_x == SOF_LX)) begin
            done_d  = 1'b1;
            state_d = WAIT_SOF;
          end
        end
      end
      IN_FRAME: begin
        if (accept) begin
          if (bus.first && !exp_first) begin
            // Early start-of-frame: resynchronise on it rather than dropping it.
            err_d     = 1'b1;
            push      = 1'b1;
            adv       = 1'b1;
            base_x    = '0;
            base_y    = '0;
            base_addr = '0;
          end else if ((bus.first == exp_first) && (bus.last_x == exp_lx) &&
                       (bus.last_y == exp_ly)) begin
            push = 1'b1;
            adv  = 1'b1;
            if (exp_ly) begin
              done_d  = 1'b1;
              state_d = WAIT_SOF;
            end
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_SOF;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase

    if (adv) begin
      if (base_x == XW'(X_RES - 1)) begin
        x_d = '0;
        y_d = (base_y == YW'(Y_RES - 1)) ? '0 : base_y + YW'(1);
      end else begin
        x_d = base_x + XW'(1);
        y_d = base_y;
      end
      addr_d = base_addr + ADDR_WIDTH'(1);
    end

    if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Write FIFO; ready and the show-ahead head are registered from the next-cycle state.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[IW-1:0]] = {base_addr, beat};
    wr_ptr_d               = wr_ptr_q + PW'(push);
    rd_ptr_d               = rd_ptr_q + PW'(pop);
    count_d                = wr_ptr_d - rd_ptr_d;
    ready_d                = (count_d != PW'(FIFO_DEPTH));
    wr_en_d                = (count_d != '0);
    {wr_addr_d, wr_data_d} = mem_d[rd_ptr_d[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= WAIT_SOF;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [23:0] sum_q, sum_d;
  logic [23:0] checksum_q, checksum_d;

  // Every pushed beat carrying first=1 opens a frame, so it restarts the sum.
  always_comb begin
    sum_d      = sum_q;
    checksum_d = checksum_q;
    if (push) sum_d = bus.first ? beat : sum_q + beat;
    if (done_d) checksum_d = sum_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q      <= '0;
      checksum_q <= '0;
    end else begin
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
    end
  end

  assign frame_checksum = checksum_q;
`else
  assign frame_checksum = '0;
`endif

  assign bus.ready   = ready_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign frame_done  = done_q;
  assign err_pulse   = err_q;
  assign err_count   = err_cnt_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Bench for pixel_stream_sink at X_RES=4, Y_RES=2: stimulus table plus scoreboarded write checks.
module tb_pixel_stream_sink;
  localparam int unsigned XR = 4;
  localparam int unsigned YR = 2;
  localparam int unsigned FD = 4;
  localparam int unsigned AW = 19;

  typedef struct {
    logic [23:0]   data;
    logic          first;
    logic          lx;
    logic          ly;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic          exp_err;
    logic          exp_done;
    logic          ckpt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_done;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] frame_count;
  logic [23:0] frame_checksum;

  pixel_stream_sink_if #(.ADDR_WIDTH(AW)) bus ();

  pixel_stream_sink #(
    .X_RES(XR), .Y_RES(YR), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .frame_done     (frame_done),
    .err_pulse      (err_pulse),
    .err_count      (err_count),
    .frame_count    (frame_count),
    .frame_checksum (frame_checksum)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        tbl[$];
  wr_t         sbq[$];
  logic [23:0] cs_model;
  logic [23:0] cs_exp;
  int          fc_exp;
  int          ec_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [23:0] d, input logic f, input logic lx, input logic ly,
                              input logic w, input int a, input logic e, input logic dn,
                              input logic ck);
    vec_t v;
    v.data = d; v.first = f; v.lx = lx; v.ly = ly;
    v.exp_wr = w; v.exp_addr = AW'(a); v.exp_err = e; v.exp_done = dn; v.ckpt = ck;
    return v;
  endfunction

  // Clean 4x2 frame at pixel i: data base+i, address i.
  function automatic vec_t clean(input logic [23:0] base, input int i, input logic ck);
    return mk(24'(base + 24'(i)), i == 0, (i % 4) == 3, i == 7, 1'b1, i, 1'b0, i == 7, ck);
  endfunction

  // Drive one beat, wait (bounded) for the handshake, then check the pulses it must cause.
  task automatic send(input vec_t v);
    int   cyc = 0;
    logic took;
    bus.valid = 1'b1; bus.r = v.data[7:0]; bus.g = v.data[15:8]; bus.b = v.data[23:16];
    bus.first = v.first; bus.last_x = v.lx; bus.last_y = v.ly;
    do begin
      @(negedge clk);
      took = bus.ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!took && cyc < 50);
    bus.valid = 1'b0;
    if (!took) begin
      check("accept_timeout", 32'(took), 32'd1);
    end else begin
      check("err_pulse", 32'(err_pulse), 32'(v.exp_err));
      check("frame_done", 32'(frame_done), 32'(v.exp_done));
      if (v.exp_wr) begin
        sbq.push_back('{v.exp_addr, v.data});
        cs_model = v.first ? v.data : cs_model + v.data;
      end
      if (v.exp_done) begin
        fc_exp++;
        cs_exp = cs_model;
      end
      if (v.exp_err) ec_exp++;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while (sbq.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("drain_left", 32'(sbq.size()), 32'd0);
  endtask

  task automatic status();
    check("frame_count", 32'(frame_count), 32'(fc_exp));
    check("err_count", 32'(err_count), 32'(ec_exp));
`ifdef FRAME_CHECKSUM_EN
    check("frame_checksum", 32'(frame_checksum), 32'(cs_exp));
`else
    check("frame_checksum", 32'(frame_checksum), 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.valid = 1'b0; bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_pulses", 32'({frame_done, err_pulse}), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_checksum", 32'(frame_checksum), 32'd0);
    sbq.delete();
    cs_model = '0; cs_exp = '0; fc_exp = 0; ec_exp = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(bus.ready), 32'd1);
  endtask

  // Write-side scoreboard: every retiring write must match the oldest expected one.
  wr_t got;
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.wr_en && bus.wr_ready) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %06h, no write expected", bus.wr_addr,
                 bus.wr_data);
      end else begin
        got = sbq.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(got.addr));
        check("wr_data", 32'(bus.wr_data), 32'(got.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.valid = 1'b0; bus.r = '0; bus.g = '0; bus.b = '0;
    bus.first = 1'b0; bus.last_x = 1'b0; bus.last_y = 1'b0; bus.wr_ready = 1'b1;

    // Clean frame with data 1..8 (sum 0x24).
    for (int i = 0; i < 8; i++) tbl.push_back(clean(24'h000001, i, i == 7));
    // Missing last_x at (3,0), junk beats discarded, then a clean frame.
    for (int i = 0; i < 3; i++) tbl.push_back(clean(24'h000A00, i, 1'b0));
    tbl.push_back(mk(24'h000A03, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(24'h000A04, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(24'h000A07, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) tbl.push_back(clean(24'h300000, i, i == 7));
    // Unexpected first at (2,1): written at 0, frame resumes at x=1.
    for (int i = 0; i < 6; i++) tbl.push_back(clean(24'h004000, i, 1'b0));
    tbl.push_back(mk(24'h0040FF, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i < 8; i++) tbl.push_back(clean(24'h450000, i, i == 7));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i]);
      if (tbl[i].ckpt) begin
        drain();
        status();
      end
`ifdef FRAME_CHECKSUM_EN
      if (i == 7) check("checksum_1to8", 32'(frame_checksum), 32'h24);
`endif
    end

    // Back-pressure: FIFO fills after 4 accepts, then drains in order.
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(clean(24'h005000, i, 1'b0));
    check("ready_full", 32'(bus.ready), 32'd0);
    check("wr_en_full", 32'(bus.wr_en), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ready_stall", 32'(bus.ready), 32'd0);
    check("held_writes", 32'(sbq.size()), 32'd4);
    bus.wr_ready = 1'b1;
    for (int i = 4; i < 8; i++) send(clean(24'h005000, i, 1'b0));
    drain();
    status();

    // Reset mid-frame with a full FIFO: contents and partial frame are discarded.
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(clean(24'h006000, i, 1'b0));
    do_reset();
    send(mk(24'h006005, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    send(mk(24'h006006, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    send(mk(24'h006007, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    check("no_write_after_rst", 32'(bus.wr_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      v = clean(24'h070000, i, 1'b0);
      send(v);
    end
    drain();
    status();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
